// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int CNT_W      = 4;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // IDLE: buffer empty; WAIT: buffer full and contending; STALL: pipeline frozen
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for an MDU result waiting for the write port.
// Load and clear are never asserted together by the arbiter; load wins if so.
module wb_hold_buf
   import wb_port_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [REG_ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0]     load_data,
   output logic                  valid,
   output logic [REG_ADDR_W-1:0] addr,
   output logic [DATA_W-1:0]     data
);

   // Capture on load; an empty buffer reads back zero address and data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         addr  <= REG_ZERO;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         addr  <= load_addr;
         data  <= load_data;
      end else if (clear) begin
         valid <= 1'b0;
         addr  <= REG_ZERO;
         data  <= '0;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-port arbiter: pipeline writeback has priority, MDU results wait in a
// one-entry buffer, and a starvation counter forces a one-cycle stall so the
// buffered result always drains.
//
// Handshake: an MDU result transfers on a rising edge where
// mdu_valid && mdu_ready; mdu_ready depends only on state, never on mdu_valid.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pl_wena,
   input  logic [4:0]  pl_waddr,
   input  logic [31:0] pl_wdata,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_waddr,
   input  logic [31:0] mdu_wdata,
   output logic        mdu_ready,
   output logic        pl_stall,
   output logic        hb_valid,
   output logic [4:0]  hb_addr,
   output logic        w1_ena,
   output logic [4:0]  w1_addr,
   output logic [31:0] w1_data,
   output logic [1:0]  dbg_state
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   arb_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   logic             pl_req;
   logic             accept;
   logic             grant_pl;
   logic             grant_hb;
   logic             waw_drop;
   logic             hb_load;
   logic             hb_clear;
   logic [31:0]      hb_data;

   // Moore outputs decoded straight from the state register.
   assign mdu_ready = (state == ST_IDLE);
   assign pl_stall  = (state == ST_STALL);
   assign dbg_state = state;

   // Decide who owns the port this cycle and how the buffer moves.
   always_comb begin
      pl_req   = pl_wena && (pl_waddr != REG_ZERO);
      accept   = mdu_valid && (state == ST_IDLE) && (mdu_waddr != REG_ZERO);
      cnt_inc  = cnt + 4'd1;
      grant_pl = 1'b0;
      grant_hb = 1'b0;
      waw_drop = 1'b0;
      case (state)
         ST_IDLE: begin
            grant_pl = pl_req;
         end
         ST_WAIT: begin
            if (pl_req) begin
               grant_pl = 1'b1;
               // younger pipeline value to the same register supersedes the buffer
               waw_drop = (pl_waddr == hb_addr);
            end else begin
               grant_hb = 1'b1;
            end
         end
         ST_STALL: begin
            grant_hb = 1'b1;
         end
         default: begin
            grant_pl = 1'b0;
         end
      endcase
      hb_load  = accept;
      hb_clear = grant_hb || waw_drop;
   end

   // Drive the regfile port from the granted source, zero when idle.
   always_comb begin
      w1_ena  = grant_pl || grant_hb;
      w1_addr = REG_ZERO;
      w1_data = '0;
      if (grant_pl) begin
         w1_addr = pl_waddr;
         w1_data = pl_wdata;
      end else if (grant_hb) begin
         w1_addr = hb_addr;
         w1_data = hb_data;
      end
   end

   // Arbitration FSM and starvation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end
            end
            ST_WAIT: begin
               if (!pl_req || waw_drop) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == LIMIT_C) begin
                     state <= ST_STALL;
                  end
               end
            end
            ST_STALL: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   wb_hold_buf u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (hb_load),
      .clear     (hb_clear),
      .load_addr (mdu_waddr),
      .load_data (mdu_wdata),
      .valid     (hb_valid),
      .addr      (hb_addr),
      .data      (hb_data)
   );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// each cycle checked against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;
   localparam int W = 48;

   logic        clk;
   logic        rst;
   logic        pl_wena;
   logic [4:0]  pl_waddr;
   logic [31:0] pl_wdata;
   logic        mdu_valid;
   logic [4:0]  mdu_waddr;
   logic [31:0] mdu_wdata;
   logic        mdu_ready;
   logic        pl_stall;
   logic        hb_valid;
   logic [4:0]  hb_addr;
   logic        w1_ena;
   logic [4:0]  w1_addr;
   logic [31:0] w1_data;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   // model state: pending MDU results, cycles denied, stall scheduled
   ent_t pend_q[$];
   int   denied = 0;
   bit   stall_next = 1'b0;

   wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .pl_wena   (pl_wena),
      .pl_waddr  (pl_waddr),
      .pl_wdata  (pl_wdata),
      .mdu_valid (mdu_valid),
      .mdu_waddr (mdu_waddr),
      .mdu_wdata (mdu_wdata),
      .mdu_ready (mdu_ready),
      .pl_stall  (pl_stall),
      .hb_valid  (hb_valid),
      .hb_addr   (hb_addr),
      .w1_ena    (w1_ena),
      .w1_addr   (w1_addr),
      .w1_data   (w1_data),
      .dbg_state (dbg_state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      pl_wena = 1'b0; pl_waddr = '0; pl_wdata = '0;
      mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
   endtask

   // Apply one cycle of inputs, predict the cycle's outputs, advance a clock.
   task automatic drive_cycle(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md);
      logic        e, stl, rdy, hv;
      logic [4:0]  wa, ha;
      logic [31:0] wd;
      logic [1:0]  st;
      ent_t        ne;
      pl_wena = pe; pl_waddr = pa; pl_wdata = pd;
      mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
      rdy = (pend_q.size() == 0);
      hv  = !rdy;
      ha  = hv ? pend_q[0].addr : 5'd0;
      stl = stall_next;
      st  = stl ? ST_STALL : (hv ? ST_WAIT : ST_IDLE);
      e = 1'b0; wa = '0; wd = '0;
      if (stl) begin
         e = 1'b1; wa = pend_q[0].addr; wd = pend_q[0].data;
         pend_q.delete(); stall_next = 1'b0; denied = 0;
      end else if (!hv) begin
         if (pe && pa != 5'd0) begin
            e = 1'b1; wa = pa; wd = pd;
         end
         if (mv && ma != 5'd0) begin
            ne.addr = ma; ne.data = md;
            pend_q.push_back(ne); denied = 0;
         end
      end else if (pe && pa != 5'd0) begin
         e = 1'b1; wa = pa; wd = pd;
         if (pa == pend_q[0].addr) begin
            pend_q.delete(); denied = 0;
         end else begin
            denied++;
            if (denied == STARVE_LIMIT) stall_next = 1'b1;
         end
      end else begin
         e = 1'b1; wa = pend_q[0].addr; wd = pend_q[0].data;
         pend_q.delete(); denied = 0;
      end
      exp_q.push_back({e, wa, wd, stl, rdy, hv, ha, st});
      @(posedge clk);
      #1;
   endtask

   // monitor: compare every predicted cycle against the DUT mid-cycle
   initial begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {w1_ena, w1_addr, w1_data, pl_stall, mdu_ready, hb_valid, hb_addr, dbg_state};
            total++;
            if (got_v !== exp_v) begin
               bad++;
               $display("FAIL port_cycle t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
         end
      end
   end

   // watchdog
   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            {44'd0, w1_ena, w1_addr, w1_data, pl_stall, mdu_ready, hb_valid, hb_addr, dbg_state},
            {44'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0});
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // idle drain
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // starvation: buffered r9 against a continuous pipeline stream to r3
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999);
      for (int i = 0; i < 7; i++)
         drive_cycle(1'b1, 5'd3, 32'h3000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);

      // WAW: younger pipeline write to r4 supersedes buffered r4
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_AAAA);
      drive_cycle(1'b1, 5'd4, 32'h0000_BBBB, 1'b0, 5'd0, 32'd0);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // zero register on both sources
      drive_cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hCAFE_F00D);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // simultaneous accept and pipeline write in IDLE, then back-pressure
      drive_cycle(1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd10, 32'h0A0A_0A0A);
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b1, 5'd6, 32'h6000_0000 + 32'(i), 1'b1, 5'd11, 32'h0B0B_0B0B);
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h0B0B_0B0B);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // reset in the middle of WAIT with r5 buffered
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5555_5555);
      drive_cycle(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
      idle_inputs();
      #2;
      rst = 1'b1;
      #1;
      check("mid_reset_outputs",
            {44'd0, w1_ena, w1_addr, w1_data, pl_stall, mdu_ready, hb_valid, hb_addr, dbg_state},
            {44'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0});
      pend_q.delete();
      denied = 0;
      stall_next = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // random traffic over a small register range to provoke collisions
      for (int i = 0; i < 2000; i++) begin
         drive_cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      end
      drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
